// File: rtl/spi_rom_pkg.sv
// Shared constants and FSM encoding for the SPI/QSPI ROM arbiter.
// Optional SPI_ROM_ARB_RR_EN (round-robin arbitration) is handled in spi_rom_arbiter.
package spi_rom_pkg;

  localparam logic [7:0]  CMD_READ    = 8'h03;
  localparam logic [7:0]  CMD_QREAD   = 8'h6B;
  localparam int unsigned CMD_BITS    = 8;
  localparam int unsigned ADDR_BITS   = 24;
  localparam int unsigned QDUMMY_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    GAP
  } state_e;

  function automatic logic [7:0] cmd_for(input logic quad);
    return quad ? CMD_QREAD : CMD_READ;
  endfunction

endpackage

// File: rtl/spi_rom_phy.sv
// SPI bit engine: sclk phase generator, MOSI shifter and input bit/nibble
// assembler with a registered byte-valid strobe.
module spi_rom_phy (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_i,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        sample_i,
  input  logic        quad_i,
  input  logic [3:0]  spi_in_i,
  output logic        tick_o,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        byte_last_o,
  output logic        valid_o,
  output logic [7:0]  data_o
);

  logic        ph_q;
  logic [31:0] mosi_q;
  logic [7:0]  in_q;
  logic [2:0]  in_cnt_q;
  logic        valid_q;
  logic [7:0]  data_q;
  logic [7:0]  byte_next;

  // tick marks the edge that ends the sclk-high phase (ph 1->0)
  assign tick_o      = cs_i & ph_q;
  assign sclk_o      = ph_q;
  assign mosi_o      = mosi_q[31];
  assign byte_next   = quad_i ? {in_q[3:0], spi_in_i} : {in_q[6:0], spi_in_i[1]};
  assign byte_last_o = sample_i & tick_o & (quad_i ? in_cnt_q[0] : (in_cnt_q == 3'd7));
  assign valid_o     = valid_q;
  assign data_o      = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q     <= 1'b0;
      mosi_q   <= '0;
      in_q     <= '0;
      in_cnt_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      ph_q    <= cs_i ? ~ph_q : 1'b0;
      valid_q <= byte_last_o;
      if (load_i) begin
        mosi_q   <= word_i;
        in_cnt_q <= '0;
      end else if (tick_o) begin
        mosi_q <= {mosi_q[30:0], 1'b0};
      end
      if (sample_i && tick_o) begin
        in_q     <= byte_next;
        in_cnt_q <= byte_last_o ? 3'd0 : in_cnt_q + 3'd1;
      end
      if (byte_last_o) data_q <= byte_next;
    end
  end

endmodule

// File: rtl/spi_rom_arbiter.sv
// Two-port SPI/QSPI ROM read arbiter and transaction sequencer.
// Define SPI_ROM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module spi_rom_arbiter
  import spi_rom_pkg::*;
#(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned GAP_CLKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [23:0]      addr0,
  input  logic [23:0]      addr1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             quad0,
  input  logic             quad1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_id,
  output logic             spi_cs,
  output logic             spi_sclk,
  input  logic [3:0]       spi_in,
  output logic             spi_out0,
  output logic             spi_dir0
);

  // The IDLE grant cycle is itself a CS-low cycle, so GAP holds one fewer
  // cycle to give exactly GAP_CLKS low cycles when a request is waiting.
  localparam int unsigned GAP_LEN = (GAP_CLKS > 1) ? GAP_CLKS - 1 : 1;
  localparam int unsigned GW      = $clog2(GAP_LEN + 1);
  localparam logic [GW-1:0] GAP_FIRST = GW'(GAP_LEN - 1);

  state_e           state_q, state_d;
  logic             id_q, id_d;
  logic             quad_q, quad_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             cs_q, cs_d;
  logic             dir_q, dir_d;

  logic             gnt_any, pick1, load;
  logic [23:0]      sel_addr;
  logic [LEN_W-1:0] sel_len;
  logic             sel_quad;
  logic             tick, byte_last, gap_first;

`ifdef SPI_ROM_ARB_RR_EN
  logic last_q, last_d;
  assign pick1 = req1 & (~req0 | ~last_q);
`else
  assign pick1 = req1 & ~req0;
`endif

  assign gnt_any  = reset & (state_q == IDLE) & (req0 | req1);
  assign gnt0     = gnt_any & ~pick1;
  assign gnt1     = gnt_any & pick1;
  assign sel_addr = pick1 ? addr1 : addr0;
  assign sel_len  = pick1 ? len1  : len0;
  assign sel_quad = pick1 ? quad1 : quad0;

  assign gap_first = (state_q == GAP) && (gap_q == GAP_FIRST);
  assign done0     = gap_first & ~id_q;
  assign done1     = gap_first & id_q;
  assign rd_id     = id_q;
  assign spi_cs    = cs_q;
  assign spi_dir0  = dir_q;

  spi_rom_phy u_phy (
    .clk         (clk),
    .rst_n       (reset),
    .cs_i        (cs_q),
    .load_i      (load),
    .word_i      ({cmd_for(sel_quad), sel_addr}),
    .sample_i    (state_q == DATA),
    .quad_i      (quad_q),
    .spi_in_i    (spi_in),
    .tick_o      (tick),
    .sclk_o      (spi_sclk),
    .mosi_o      (spi_out0),
    .byte_last_o (byte_last),
    .valid_o     (rd_valid),
    .data_o      (rd_data)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    quad_d  = quad_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    cs_d    = cs_q;
    dir_d   = dir_q;
    load    = 1'b0;
`ifdef SPI_ROM_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          id_d   = pick1;
          quad_d = sel_quad;
          len_d  = sel_len;
`ifdef SPI_ROM_ARB_RR_EN
          last_d = pick1;
`endif
          if (sel_len == '0) begin
            state_d = GAP;
            gap_d   = GAP_FIRST;
          end else begin
            state_d = CMD;
            cs_d    = 1'b1;
            cnt_d   = '0;
            load    = 1'b1;
          end
        end
      end
      CMD: begin
        if (tick) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(CMD_BITS - 1)) begin
            cnt_d   = '0;
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (tick) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(ADDR_BITS - 1)) begin
            cnt_d   = '0;
            dir_d   = 1'b1;
            state_d = quad_q ? DUMMY : DATA;
          end
        end
      end
      DUMMY: begin
        if (tick) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(QDUMMY_BITS - 1)) begin
            cnt_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (byte_last) begin
          len_d = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            state_d = GAP;
            cs_d    = 1'b0;
            dir_d   = 1'b0;
            gap_d   = GAP_FIRST;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      quad_q  <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      cs_q    <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      quad_q  <= quad_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      cs_q    <= cs_d;
      dir_q   <= dir_d;
    end
  end

`ifdef SPI_ROM_ARB_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

endmodule
